// File: rtl/dm_loader_if.sv
// Load-job, input-stream and data-memory write pins of the PE data-memory loader.
// master = job/stream source side, slave = dm_loader.
interface dm_loader_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int DM_ADDR_WIDTH = 8,
  parameter int INST_WIDTH    = 64
);
  logic                      cfg_v;
  logic                      cfg_rdy;
  logic [DM_ADDR_WIDTH-1:0]  cfg_base;
  logic [DM_ADDR_WIDTH:0]    cfg_len;
  logic                      s_valid;
  logic                      s_ready;
  logic [2*DATA_WIDTH-1:0]   s_data;
  logic                      dm_inst_v;
  logic [INST_WIDTH-1:0]     dm_inst;
  logic                      dm_wren;
  logic [2*DATA_WIDTH-1:0]   dm_wdata;
  logic                      busy;
  logic                      done;

  modport master (
    output cfg_v, cfg_base, cfg_len, s_valid, s_data,
    input  cfg_rdy, s_ready, dm_inst_v, dm_inst, dm_wren, dm_wdata, busy, done
  );

  modport slave (
    input  cfg_v, cfg_base, cfg_len, s_valid, s_data,
    output cfg_rdy, s_ready, dm_inst_v, dm_inst, dm_wren, dm_wdata, busy, done
  );
endinterface

// File: rtl/dm_loader.sv
// Write-side sequencer for a PE data memory: one address instruction, then len streamed words
// written at consecutive addresses; done pulses once the last write has reached the memory.
module dm_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int DM_ADDR_WIDTH = 8,
  parameter int INST_WIDTH    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_loader_if.slave   bus
);
  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [DM_ADDR_WIDTH:0] CNT_ONE = (DM_ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {IDLE, ADDR, LOAD, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [DM_ADDR_WIDTH:0]  len_q;
  logic [DM_ADDR_WIDTH:0]  cnt_q;
  logic [DM_ADDR_WIDTH:0]  cnt_d;
  logic                    drain_q;
  logic [WW-1:0]           data_q;
  logic [WW-1:0]           wdata_q;
  logic [INST_WIDTH-1:0]   inst_q;
  logic                    inst_v_q;
  logic                    wren_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    s_ready;
  logic                    accept;

  assign s_ready = (state_q == LOAD);
  assign accept  = bus.s_valid && s_ready;
  assign cnt_d   = cnt_q + CNT_ONE;

  assign bus.cfg_rdy   = (state_q == IDLE);
  assign bus.s_ready   = s_ready;
  assign bus.dm_inst_v = inst_v_q;
  assign bus.dm_inst   = inst_q;
  assign bus.dm_wren   = wren_q;
  assign bus.dm_wdata  = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      data_q   <= '0;
      wdata_q  <= '0;
      inst_q   <= '0;
      inst_v_q <= 1'b0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // The memory registers wren, so data trails wren by one cycle through data_q.
      inst_v_q <= 1'b0;
      wren_q   <= accept;
      done_q   <= (state_q == DONE);
      if (accept) data_q <= bus.s_data;
      if (wren_q) wdata_q <= data_q;

      unique case (state_q)
        IDLE: begin
          if (bus.cfg_v) begin
            len_q  <= bus.cfg_len;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            inst_q <= '0;
            inst_q[16 +: DM_ADDR_WIDTH] <= bus.cfg_base;
            if (bus.cfg_len == '0) begin
              state_q <= DONE;
            end else begin
              state_q  <= ADDR;
              inst_v_q <= 1'b1;
            end
          end
        end
        ADDR: state_q <= LOAD;
        LOAD: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              state_q <= DRAIN;
              drain_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the final word pass wren -> memory wren register -> write.
          drain_q <= ~drain_q;
          if (drain_q) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_loader.sv
// Bench for dm_loader: table of load jobs plus held-cfg and async-reset sequences, with a
// behavioural data memory and a scoreboard of expected {address, word} writes.
module tb_dm_loader;
  logic clk;
  logic rst_n;

  dm_loader_if #(.DATA_WIDTH(16), .DM_ADDR_WIDTH(8), .INST_WIDTH(64)) bus ();

  dm_loader #(.DATA_WIDTH(16), .DM_ADDR_WIDTH(8), .INST_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // word source feeding the stream, gated by a per-job valid pattern
  logic [31:0] src_arr [1024];
  int          src_wr = 0;
  int          src_rd = 0;
  logic [7:0]  pat    = 8'h01;
  int          plen   = 1;

  initial begin
    int pidx;
    pidx        = 0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.s_ready) begin
        bus.s_valid = pat[pidx % plen] && (src_rd < src_wr);
        bus.s_data  = src_arr[src_rd % 1024];
        pidx++;
      end else begin
        bus.s_valid = 1'b0;
        pidx        = 0;
      end
    end
  end

  // memory model, scoreboard and event monitor, all sampled on the falling edge
  logic [31:0] mem [256];
  logic [7:0]  mem_addr   = 8'h00;
  logic        mem_wren_r = 1'b0;
  logic [7:0]  exp_addr   = 8'h00;
  logic [7:0]  exp_base   = 8'h00;
  logic [39:0] exp_q [$];
  int          wcyc_q [$];
  int t0 = 0, last_acc = 0, inst_cnt = 0, wren_cnt = 0;
  int acc_cnt = 0, s_acc_cnt = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst_n) begin
      exp_q.delete();
      wcyc_q.delete();
      mem_wren_r = 1'b0;
      src_rd     = src_wr;
    end else begin
      if (bus.dm_inst_v) begin
        inst_cnt++;
        chk("inst_v_cycle", cyc, t0 + 1);
        chk("inst_word", bus.dm_inst, {40'h0, exp_base, 16'h0});
        chk("inst_v_vs_mem_wren", mem_wren_r, 0);
      end
      if (mem_wren_r) begin
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e[39:32]);
          chk("write_data", bus.dm_wdata, e[31:0]);
        end
        mem[mem_addr] = bus.dm_wdata;
        mem_addr++;
      end
      mem_wren_r = bus.dm_wren;
      if (bus.dm_inst_v) mem_addr = bus.dm_inst[23:16];
      if (bus.dm_wren) begin
        wren_cnt++;
        chk("wren_expected", wcyc_q.size() > 0, 1);
        if (wcyc_q.size() > 0) chk("wren_cycle", cyc, wcyc_q.pop_front());
      end
      if (bus.cfg_v && bus.cfg_rdy) begin
        acc_cnt++;
        t0       = cyc;
        exp_base = bus.cfg_base;
        exp_addr = bus.cfg_base;
        inst_cnt = 0;
        wren_cnt = 0;
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({exp_addr, bus.s_data});
        exp_addr++;
        wcyc_q.push_back(cyc + 1);
        last_acc = cyc;
        s_acc_cnt++;
        src_rd++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [7:0]  pat;
    int          plen;
    logic [31:0] seed;
    int          done_off;
  } vec_t;

  task automatic push_words(input logic [31:0] seed, input int n);
    for (int i = 0; i < n; i++) begin
      src_arr[src_wr % 1024] = seed + 32'(i);
      src_wr++;
    end
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_cfg_rdy"}, bus.cfg_rdy, 1);
    chk({pfx, "_s_ready"}, bus.s_ready, 0);
    chk({pfx, "_inst_v"}, bus.dm_inst_v, 0);
    chk({pfx, "_wren"}, bus.dm_wren, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_inst"}, bus.dm_inst, 0);
    chk({pfx, "_wdata"}, bus.dm_wdata, 0);
  endtask

  task automatic start_cfg(input logic [7:0] base, input logic [8:0] len);
    int a0;
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.cfg_v    = 1'b1;
    bus.cfg_base = base;
    bus.cfg_len  = len;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("cfg_accept", acc_cnt, a0 + 1);
    bus.cfg_v = 1'b0;
  endtask

  task automatic wait_done(input int d_target, input int budget);
    for (int i = 0; i < budget && done_cnt < d_target; i++) begin
      @(posedge clk);
      #1;
    end
    chk("done_seen", done_cnt, d_target);
  endtask

  task automatic check_mem(input logic [7:0] base, input int n, input logic [31:0] seed);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      chk("mem_content", mem[a], seed + 32'(i));
    end
  endtask

  task automatic run_job(input vec_t v);
    int d0;
    push_words(v.seed, int'(v.len));
    pat  = v.pat;
    plen = v.plen;
    d0   = done_cnt;
    start_cfg(v.base, v.len);
    wait_done(d0 + 1, int'(v.len) + 40);
    chk("done_cycle", done_cyc, t0 + v.done_off);
    if (v.len != 0) chk("done_after_last_accept", done_cyc, last_acc + 4);
    chk("inst_v_count", inst_cnt, (v.len != 0) ? 1 : 0);
    chk("wren_count", wren_cnt, v.len);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    check_mem(v.base, int'(v.len), v.seed);
    if (v.len != 0) chk("wdata_hold", bus.dm_wdata, v.seed + 32'(v.len) - 1);
  endtask

  initial begin
    vec_t vecs [5];
    int   d0, a0, s0, t1;

    vecs[0] = '{base: 8'h10, len: 9'd4,   pat: 8'h01,       plen: 1, seed: 32'hA0,   done_off: 9};
    vecs[1] = '{base: 8'hFE, len: 9'd4,   pat: 8'h01,       plen: 1, seed: 32'hB0,   done_off: 9};
    vecs[2] = '{base: 8'h33, len: 9'd3,   pat: 8'b0010_1001, plen: 6, seed: 32'hC0,  done_off: 11};
    vecs[3] = '{base: 8'h55, len: 9'd0,   pat: 8'h01,       plen: 1, seed: 32'h0,    done_off: 2};
    vecs[4] = '{base: 8'h00, len: 9'd256, pat: 8'h01,       plen: 1, seed: 32'h1000, done_off: 261};

    rst_n        = 1'b0;
    bus.cfg_v    = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_len  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_job(vecs[k]);

    // cfg_v held through a whole job: the second request waits for the first IDLE cycle
    push_words(32'hD0, 8);
    push_words(32'hE0, 2);
    pat  = 8'h01;
    plen = 1;
    d0   = done_cnt;
    a0   = acc_cnt;
    @(posedge clk);
    #1;
    bus.cfg_v    = 1'b1;
    bus.cfg_base = 8'h20;
    bus.cfg_len  = 9'd8;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
      @(posedge clk);
      #1;
    end
    t1           = t0;
    bus.cfg_base = 8'h40;
    bus.cfg_len  = 9'd2;
    for (int i = 0; i < 40 && acc_cnt < a0 + 2; i++) begin
      @(posedge clk);
      #1;
    end
    bus.cfg_v = 1'b0;
    chk("held_cfg_accepts", acc_cnt, a0 + 2);
    chk("second_job_start", t0, t1 + 13);
    chk("first_done_before_second", done_cnt, d0 + 1);
    wait_done(d0 + 2, 40);
    check_mem(8'h20, 8, 32'hD0);
    check_mem(8'h40, 2, 32'hE0);

    // asynchronous reset after the second of five words abandons the job
    push_words(32'hF0, 5);
    s0 = s_acc_cnt;
    start_cfg(8'h80, 9'd5);
    for (int i = 0; i < 20 && s_acc_cnt < s0 + 2; i++) begin
      @(posedge clk);
      #1;
    end
    chk("two_words_before_reset", s_acc_cnt, s0 + 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, d0);
    run_job('{base: 8'h00, len: 9'd2, pat: 8'h01, plen: 1, seed: 32'h5A5A_0000, done_off: 7});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "timeout");
  end
endmodule
